// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - shared types and defaults for the collision checker
package collision_pkg;

    localparam int TREX_BOX_COUNT_DEF     = 6;
    localparam int OBSTACLE_BOX_COUNT_DEF = 5;
    localparam int COORD_W_DEF            = 12;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] width;
        logic [9:0] height;
    } collision_box_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COARSE,
        ST_FINE,
        ST_DONE
    } chk_state_t;

endpackage

// File: rtl/collision_checker_rect_overlap.sv
// rtl/collision_checker_rect_overlap.sv - combinational strict-overlap test of two absolute rectangles
module rect_overlap #(
    parameter int COORD_W = 12
) (
    input  logic signed [COORD_W-1:0] a_x,
    input  logic signed [COORD_W-1:0] a_y,
    input  logic signed [COORD_W-1:0] a_w,
    input  logic signed [COORD_W-1:0] a_h,
    input  logic signed [COORD_W-1:0] b_x,
    input  logic signed [COORD_W-1:0] b_y,
    input  logic signed [COORD_W-1:0] b_w,
    input  logic signed [COORD_W-1:0] b_h,
    output logic                      overlap
);

    logic a_empty;
    logic b_empty;

    assign a_empty = (a_w == '0) || (a_h == '0);
    assign b_empty = (b_w == '0) || (b_h == '0);

    // Strict compares: rectangles that only share an edge are not a collision.
    assign overlap = !a_empty && !b_empty
                   && (a_x < b_x + b_w) && (b_x < a_x + a_w)
                   && (a_y < b_y + b_h) && (b_y < a_y + a_h);

endmodule

// File: rtl/collision_checker.sv
// rtl/collision_checker.sv - sequential T-rex/obstacle box collision check; COLLISION_COARSE_EN adds a bounding pre-test
module collision_checker
    import collision_pkg::*;
#(
    parameter int TREX_BOX_COUNT     = TREX_BOX_COUNT_DEF,
    parameter int OBSTACLE_BOX_COUNT = OBSTACLE_BOX_COUNT_DEF,
    parameter int COORD_W            = COORD_W_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      clear,
    input  logic [9:0]                                trex_x,
    input  logic [9:0]                                trex_y,
    input  logic [9:0]                                trex_width,
    input  logic [9:0]                                trex_height,
    input  collision_box_t [TREX_BOX_COUNT-1:0]       trex_box,
    input  logic                                      obs_valid,
    input  logic signed [10:0]                        obs_x,
    input  logic [9:0]                                obs_y,
    input  logic [9:0]                                obs_width,
    input  logic [9:0]                                obs_height,
    input  collision_box_t [OBSTACLE_BOX_COUNT-1:0]   obs_box,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      crash,
    output logic [2:0]                                hit_trex_idx,
    output logic [2:0]                                hit_obs_idx
);

    localparam logic [2:0] TREX_LAST = 3'(TREX_BOX_COUNT - 1);
    localparam logic [2:0] OBS_LAST  = 3'(OBSTACLE_BOX_COUNT - 1);

    function automatic logic signed [COORD_W-1:0] zext10(input logic [9:0] v);
        return $signed({{(COORD_W-10){1'b0}}, v});
    endfunction

    function automatic logic signed [COORD_W-1:0] sext11(input logic signed [10:0] v);
        return $signed({{(COORD_W-11){v[10]}}, v});
    endfunction

    chk_state_t                            state;
    logic [2:0]                            idx_i;
    logic [2:0]                            idx_j;
    logic [9:0]                            lat_trex_x;
    logic [9:0]                            lat_trex_y;
    logic signed [10:0]                    lat_obs_x;
    logic [9:0]                            lat_obs_y;
    collision_box_t [TREX_BOX_COUNT-1:0]   lat_trex_box;
    collision_box_t [OBSTACLE_BOX_COUNT-1:0] lat_obs_box;

    collision_box_t cur_tb;
    collision_box_t cur_ob;
    logic           fine_hit;
    logic           coarse_hit;

    assign cur_tb = lat_trex_box[idx_i];
    assign cur_ob = lat_obs_box[idx_j];

    rect_overlap #(.COORD_W(COORD_W)) u_fine (
        .a_x     (zext10(lat_trex_x) + zext10(cur_tb.x)),
        .a_y     (zext10(lat_trex_y) + zext10(cur_tb.y)),
        .a_w     (zext10(cur_tb.width)),
        .a_h     (zext10(cur_tb.height)),
        .b_x     (sext11(lat_obs_x) + zext10(cur_ob.x)),
        .b_y     (zext10(lat_obs_y) + zext10(cur_ob.y)),
        .b_w     (zext10(cur_ob.width)),
        .b_h     (zext10(cur_ob.height)),
        .overlap (fine_hit)
    );

`ifdef COLLISION_COARSE_EN
    logic [9:0] lat_trex_w;
    logic [9:0] lat_trex_h;
    logic [9:0] lat_obs_w;
    logic [9:0] lat_obs_h;

    rect_overlap #(.COORD_W(COORD_W)) u_coarse (
        .a_x     (zext10(lat_trex_x)),
        .a_y     (zext10(lat_trex_y)),
        .a_w     (zext10(lat_trex_w)),
        .a_h     (zext10(lat_trex_h)),
        .b_x     (sext11(lat_obs_x)),
        .b_y     (zext10(lat_obs_y)),
        .b_w     (zext10(lat_obs_w)),
        .b_h     (zext10(lat_obs_h)),
        .overlap (coarse_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_trex_w <= '0;
            lat_trex_h <= '0;
            lat_obs_w  <= '0;
            lat_obs_h  <= '0;
        end else if (state == ST_IDLE && start) begin
            lat_trex_w <= trex_width;
            lat_trex_h <= trex_height;
            lat_obs_w  <= obs_width;
            lat_obs_h  <= obs_height;
        end
    end
`else
    // Outer sizes only matter to the bounding pre-test.
    logic unused_outer;
    assign unused_outer = ^{trex_width, trex_height, obs_width, obs_height};
    assign coarse_hit   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            crash        <= 1'b0;
            hit_trex_idx <= '0;
            hit_obs_idx  <= '0;
            idx_i        <= '0;
            idx_j        <= '0;
            lat_trex_x   <= '0;
            lat_trex_y   <= '0;
            lat_obs_x    <= '0;
            lat_obs_y    <= '0;
            lat_trex_box <= '0;
            lat_obs_box  <= '0;
        end else begin
            done <= 1'b0;
            // A hit in the same cycle overrides this through a later assignment.
            if (clear) begin
                crash <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_trex_x   <= trex_x;
                        lat_trex_y   <= trex_y;
                        lat_obs_x    <= obs_x;
                        lat_obs_y    <= obs_y;
                        lat_trex_box <= trex_box;
                        lat_obs_box  <= obs_box;
                        idx_i        <= '0;
                        idx_j        <= '0;
                        if (!obs_valid) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            busy <= 1'b1;
`ifdef COLLISION_COARSE_EN
                            state <= ST_COARSE;
`else
                            state <= ST_FINE;
`endif
                        end
                    end
                end
                ST_COARSE: begin
                    if (coarse_hit) begin
                        state <= ST_FINE;
                    end else begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_FINE: begin
                    if (fine_hit) begin
                        crash        <= 1'b1;
                        hit_trex_idx <= idx_i;
                        hit_obs_idx  <= idx_j;
                        state        <= ST_DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end else if (idx_i == TREX_LAST && idx_j == OBS_LAST) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (idx_j == OBS_LAST) begin
                        idx_j <= '0;
                        idx_i <= idx_i + 3'd1;
                    end else begin
                        idx_j <= idx_j + 3'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_checker.sv
// tb/tb_collision_checker.sv - directed self-checking bench for collision_checker
module tb_collision_checker;
    import collision_pkg::*;

`ifdef COLLISION_COARSE_EN
    localparam int MISS_LAT = 2;
    localparam int ADD      = 1;
`else
    localparam int MISS_LAT = 31;
    localparam int ADD      = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic start, clear;
    logic [9:0] trex_x, trex_y, trex_width, trex_height;
    collision_box_t [5:0] trex_box;
    logic obs_valid;
    logic signed [10:0] obs_x;
    logic [9:0] obs_y, obs_width, obs_height;
    collision_box_t [4:0] obs_box;
    logic busy, done, crash;
    logic [2:0] hit_trex_idx, hit_obs_idx;

    int total = 0;
    int bad = 0;
    int lat;
    int n_done;
    logic busy1;

    always #5 clk = ~clk;

    collision_checker dut (
        .clk(clk), .rst(rst_n), .start(start), .clear(clear),
        .trex_x(trex_x), .trex_y(trex_y), .trex_width(trex_width), .trex_height(trex_height),
        .trex_box(trex_box), .obs_valid(obs_valid), .obs_x(obs_x), .obs_y(obs_y),
        .obs_width(obs_width), .obs_height(obs_height), .obs_box(obs_box),
        .busy(busy), .done(done), .crash(crash),
        .hit_trex_idx(hit_trex_idx), .hit_obs_idx(hit_obs_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic collision_box_t mk_box(input int x, input int y, input int w, input int h);
        collision_box_t b;
        b.x = 10'(x); b.y = 10'(y); b.width = 10'(w); b.height = 10'(h);
        return b;
    endfunction

    task automatic set_scene(input int tx, input int ty, input int tw, input int th,
                             input int ox, input int oy, input int ow, input int oh);
        trex_x = 10'(tx); trex_y = 10'(ty); trex_width = 10'(tw); trex_height = 10'(th);
        obs_x = 11'(ox); obs_y = 10'(oy); obs_width = 10'(ow); obs_height = 10'(oh);
        for (int k = 0; k < 6; k++) trex_box[k] = mk_box(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) obs_box[k] = mk_box(0, 0, 0, 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic run_check(output int l, output logic b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        b1 = busy;
        l = -1;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                l = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; obs_valid = 1'b1;
        set_scene(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_crash", crash, 1'b0);
        chk("reset_hit_trex", hit_trex_idx, 3'd0);
        chk("reset_hit_obs", hit_obs_idx, 3'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_scene(50, 100, 40, 40, 400, 100, 40, 40);
        for (int k = 0; k < 6; k++) trex_box[k] = mk_box(0, 0, 10, 10);
        for (int k = 0; k < 5; k++) obs_box[k] = mk_box(0, 0, 10, 10);
        run_check(lat, busy1);
        chk("miss_latency", lat, MISS_LAT);
        chk("miss_busy_c1", busy1, 1'b1);
        chk("miss_crash", crash, 1'b0);

        set_scene(100, 100, 40, 40, 100, 100, 40, 40);
        trex_box[1] = mk_box(0, 0, 10, 10);
        obs_box[2] = mk_box(0, 0, 10, 10);
        run_check(lat, busy1);
        chk("hit_latency", lat, 9 + ADD);
        chk("hit_crash", crash, 1'b1);
        chk("hit_trex_idx", hit_trex_idx, 3'd1);
        chk("hit_obs_idx", hit_obs_idx, 3'd2);

        set_scene(50, 100, 40, 40, 400, 100, 40, 40);
        for (int k = 0; k < 6; k++) trex_box[k] = mk_box(0, 0, 10, 10);
        for (int k = 0; k < 5; k++) obs_box[k] = mk_box(0, 0, 10, 10);
        run_check(lat, busy1);
        chk("sticky_crash", crash, 1'b1);
        chk("sticky_trex_idx", hit_trex_idx, 3'd1);
        chk("sticky_obs_idx", hit_obs_idx, 3'd2);

        obs_valid = 1'b0;
        run_check(lat, busy1);
        chk("novalid_latency", lat, 1);
        chk("novalid_busy_c1", busy1, 1'b0);
        chk("novalid_crash", crash, 1'b1);
        obs_valid = 1'b1;

        pulse_clear();
        chk("clear_crash", crash, 1'b0);

        set_scene(100, 100, 10, 10, 110, 100, 10, 10);
        trex_box[0] = mk_box(0, 0, 10, 10);
        obs_box[0] = mk_box(0, 0, 10, 10);
        run_check(lat, busy1);
        chk("touch_latency", lat, MISS_LAT);
        chk("touch_crash", crash, 1'b0);

        obs_x = 11'sd109;
        run_check(lat, busy1);
        chk("overlap1_latency", lat, 2 + ADD);
        chk("overlap1_crash", crash, 1'b1);
        chk("overlap1_trex_idx", hit_trex_idx, 3'd0);
        chk("overlap1_obs_idx", hit_obs_idx, 3'd0);

        pulse_clear();

        set_scene(10, 100, 10, 10, -5, 100, 20, 10);
        trex_box[0] = mk_box(0, 0, 10, 10);
        obs_box[0] = mk_box(0, 0, 20, 10);
        run_check(lat, busy1);
        chk("negx_latency", lat, 2 + ADD);
        chk("negx_crash", crash, 1'b1);

        set_scene(100, 100, 40, 40, 100, 100, 40, 40);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        for (int c = 0; c < 60; c++) begin
            if (done) n_done++;
            @(posedge clk); #1;
        end
        chk("busy_start_done_count", n_done, 1);
        chk("busy_start_idle", busy, 1'b0);
        chk("busy_start_crash_kept", crash, 1'b1);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midreset_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_done", done, 1'b0);
        chk("midreset_crash", crash, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("after_reset_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
